scene_bus_responder: RTL
========================

# scene_bus_responder

Memory-side responder for the renderer's byte-multiplexed address/data bus. It decodes the two-cycle address phase, serves scene-description reads from an internal byte-addressed scene RAM, and assembles framebuffer writes (address bit 23 set) into 24-bit pixels. Assembled pixels are emitted on a one-cycle valid stream. It sits between the renderer core and the display/capture logic, and serves as the bench's memory model for the renderer.

## Interface
Parameters:
- SCENE_AW, default 6: scene RAM address width; depth is 2^SCENE_AW bytes.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_i  in  1  high only in the first address cycle of each transaction
- a_i  in  8  lane A from initiator: addr[7:0] in cycle 0, addr[23:16] in cycle 1, write data in cycle 2
- b_i  in  8  lane B from initiator: addr[15:8] in cycle 0, command in cycle 1 (0x00 = read, 0xFF = write)
- rd_data_o  out  8  read data to initiator
- ld_we_i  in  1  scene RAM load strobe
- ld_addr_i  in  SCENE_AW  scene RAM load address
- ld_data_i  in  8  scene RAM load data
- px_valid_o  out  1  one-cycle pulse; pixel complete
- px_data_o  out  24  pixel: byte0 in [7:0], byte1 in [15:8], byte2 in [23:16]
- px_addr_o  out  23  framebuffer byte address (addr[22:0]) of the pixel's byte0
- px_count_o  out  16  pixels emitted since reset; wraps 0xFFFF to 0
- err_o  out  1  sticky protocol error flag

## Operation
- The FSM has three states, IDLE, ADDR_HI and DATA, with reset state IDLE.
- IDLE: when req_i=1, latch a_i into addr_lo and b_i into addr_mid, then go to ADDR_HI. Otherwise stay.
- ADDR_HI: form addr = {a_i, addr_mid, addr_lo} and decode b_i.
  - Read (0x00): with addr[23]=0 and addr[22:SCENE_AW]=0, register rd_data_o <= scene[addr[SCENE_AW-1:0]]. Any other read address gives rd_data_o <= 0x00; addr[23]=1 additionally sets err_o.
  - Write (0xFF): latch addr, go to DATA.
  - Any other command: set err_o, go to IDLE.
  - Read completes by going to IDLE.
- DATA: capture a_i as the write byte and go to IDLE.
  - Write with addr[23]=0: byte discarded, err_o set.
  - Write with addr[23]=1: byte goes to the pixel assembler.
- req_i=1 while in ADDR_HI or DATA aborts the current transaction. It sets err_o, latches the new addr_lo/addr_mid, and goes to ADDR_HI. The aborted write byte is dropped.
- Pixel assembler:
  - Holds lane index k (0..2), an expected address exp, a base address, and a 24-bit accumulator.
  - Byte with k=0: base <= addr[22:0], acc[7:0] <= byte, exp <= addr+1, k <= 1.
  - Byte with k>0 and addr[22:0]==exp: store into acc[8k+7:8k] and advance exp. At k=2, emit the pixel and set k <= 0.
  - Byte with k>0 and addr!=exp: set err_o, discard the partial pixel, and restart the byte as k=0.
- Emit: px_valid_o=1 for exactly one cycle, px_data_o = completed acc, px_addr_o = base, px_count_o increments. px_data_o and px_addr_o hold until the next emit.
- Scene RAM:
  - ld_we_i=1 writes ld_data_i at the clock edge and is ignored while rst_n=0.
  - Contents are not cleared by reset.
  - A load and a bus read to the same address in the same cycle: the read returns the old value.
- err_o is cleared only by reset.

## Timing
- Read: req_i in cycle N, command in cycle N+1, rd_data_o valid from cycle N+2 and held until the next read's ADDR_HI edge.
- Write: data byte on a_i in cycle N+2. When that byte completes a pixel, px_valid_o is high in cycle N+3.
- Minimum transaction spacing is 3 cycles; req_i may be asserted in cycle N+3 (back-to-back).
- The initiator may idle for any number of cycles between transactions.
- Reset values: rd_data_o=0x00, px_valid_o=0, px_data_o=0, px_addr_o=0, px_count_o=0, err_o=0. Reset also sets the FSM to IDLE and k=0.
- Reset mid-transaction or mid-pixel discards all partial state.

## Test plan
- Load scene[0..3]=0x11,0x22,0x33,0x44, then read addr 0x000002 -> rd_data_o=0x33 in cycle N+2, err_o=0.
- Writes 0xAA,0xBB,0xCC to 0x800000,0x800001,0x800002 back-to-back -> one px_valid_o pulse with px_data_o=0xCCBBAA, px_addr_o=0, px_count_o=1.
- Writes to 0x800000, 0x800001, then 0x800005 -> err_o=1, no pixel. Further bytes at 0x800006 and 0x800007 -> pixel at px_addr_o=0x000005.
- Read 0x000040 with SCENE_AW=6 -> 0x00, err_o=0. Read 0x800000 -> 0x00, err_o=1. Command 0x5A -> err_o=1, FSM back to IDLE.
- req_i reasserted in DATA of a write to 0x800000 -> byte dropped, err_o=1, new transaction completes normally.
- Assert rst_n=0 after two pixel bytes, then write three fresh bytes -> only one pixel emitted, px_count_o=1.

Source files
------------

// File: rtl/scene_bus_responder.sv
// Memory-side responder for the byte-multiplexed renderer bus: scene RAM reads
// and framebuffer writes assembled into 24-bit pixels on a one-cycle valid stream.
module scene_bus_responder #(
  parameter int unsigned SCENE_AW = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_i,
  input  logic [7:0]          a_i,
  input  logic [7:0]          b_i,
  output logic [7:0]          rd_data_o,
  input  logic                ld_we_i,
  input  logic [SCENE_AW-1:0] ld_addr_i,
  input  logic [7:0]          ld_data_i,
  output logic                px_valid_o,
  output logic [23:0]         px_data_o,
  output logic [22:0]         px_addr_o,
  output logic [15:0]         px_count_o,
  output logic                err_o
);

  localparam int unsigned DEPTH = 1 << SCENE_AW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR_HI = 2'd1,
    DATA    = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  addr_lo_q, addr_lo_d;
  logic [7:0]  addr_mid_q, addr_mid_d;
  logic [23:0] waddr_q, waddr_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        err_q, err_d;
  logic [1:0]  k_q, k_d;
  logic [22:0] exp_q, exp_d;
  logic [22:0] base_q, base_d;
  logic [23:0] acc_q, acc_d;
  logic        px_valid_q, px_valid_d;
  logic [23:0] px_data_q, px_data_d;
  logic [22:0] px_addr_q, px_addr_d;
  logic [15:0] px_count_q, px_count_d;

  logic [7:0]  scene_mem [DEPTH];
  logic [23:0] addr_s;
  logic        in_range_s;
  logic        byte_valid_s;

  assign addr_s     = {a_i, addr_mid_q, addr_lo_q};
  assign in_range_s = ~addr_s[23] && ((addr_s[22:0] >> SCENE_AW) == 23'd0);

  // Scene RAM load port; contents survive reset and loads are blocked during it.
  always_ff @(posedge clk) begin
    if (rst_n && ld_we_i) begin
      scene_mem[ld_addr_i] <= ld_data_i;
    end
  end

  // Bus FSM next state plus pixel assembler.
  always_comb begin
    state_d      = state_q;
    addr_lo_d    = addr_lo_q;
    addr_mid_d   = addr_mid_q;
    waddr_d      = waddr_q;
    rd_data_d    = rd_data_q;
    err_d        = err_q;
    k_d          = k_q;
    exp_d        = exp_q;
    base_d       = base_q;
    acc_d        = acc_q;
    px_valid_d   = 1'b0;
    px_data_d    = px_data_q;
    px_addr_d    = px_addr_q;
    px_count_d   = px_count_q;
    byte_valid_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_i) begin
          addr_lo_d  = a_i;
          addr_mid_d = b_i;
          state_d    = ADDR_HI;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR_HI: begin
        if (req_i) begin
          err_d      = 1'b1;
          addr_lo_d  = a_i;
          addr_mid_d = b_i;
          state_d    = ADDR_HI;
        end else begin
          case (b_i)
            8'h00: begin
              rd_data_d = in_range_s ? scene_mem[addr_s[SCENE_AW-1:0]] : 8'h00;
              if (addr_s[23]) begin
                err_d = 1'b1;
              end else begin
                err_d = err_q;
              end
              state_d = IDLE;
            end
            8'hFF: begin
              waddr_d = addr_s;
              state_d = DATA;
            end
            default: begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          endcase
        end
      end
      DATA: begin
        if (req_i) begin
          err_d      = 1'b1;
          addr_lo_d  = a_i;
          addr_mid_d = b_i;
          state_d    = ADDR_HI;
        end else begin
          state_d = IDLE;
          if (waddr_q[23]) begin
            byte_valid_s = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A byte off the expected address flags an error and starts a new pixel.
    if (byte_valid_s) begin
      if ((k_q == 2'd0) || (waddr_q[22:0] != exp_q)) begin
        if (k_q != 2'd0) begin
          err_d = 1'b1;
        end else begin
          err_d = err_d;
        end
        base_d     = waddr_q[22:0];
        acc_d[7:0] = a_i;
        exp_d      = waddr_q[22:0] + 23'd1;
        k_d        = 2'd1;
      end else if (k_q == 2'd1) begin
        acc_d[15:8] = a_i;
        exp_d       = exp_q + 23'd1;
        k_d         = 2'd2;
      end else begin
        acc_d[23:16] = a_i;
        exp_d        = exp_q + 23'd1;
        k_d          = 2'd0;
        px_valid_d   = 1'b1;
        px_data_d    = {a_i, acc_q[15:0]};
        px_addr_d    = base_q;
        px_count_d   = px_count_q + 16'd1;
      end
    end else begin
      k_d = k_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_lo_q  <= 8'h00;
      addr_mid_q <= 8'h00;
      waddr_q    <= 24'h000000;
      rd_data_q  <= 8'h00;
      err_q      <= 1'b0;
      k_q        <= 2'd0;
      exp_q      <= 23'd0;
      base_q     <= 23'd0;
      acc_q      <= 24'h000000;
      px_valid_q <= 1'b0;
      px_data_q  <= 24'h000000;
      px_addr_q  <= 23'd0;
      px_count_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      addr_lo_q  <= addr_lo_d;
      addr_mid_q <= addr_mid_d;
      waddr_q    <= waddr_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
      k_q        <= k_d;
      exp_q      <= exp_d;
      base_q     <= base_d;
      acc_q      <= acc_d;
      px_valid_q <= px_valid_d;
      px_data_q  <= px_data_d;
      px_addr_q  <= px_addr_d;
      px_count_q <= px_count_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign err_o      = err_q;
  assign px_valid_o = px_valid_q;
  assign px_data_o  = px_data_q;
  assign px_addr_o  = px_addr_q;
  assign px_count_o = px_count_q;

endmodule
